// File: rtl/joybus_rx.sv
// Joybus receive front-end: decodes a status byte plus a 16-bit data word
// from the single-wire line, framed by rx_start and a trailing stop bit.
module joybus_rx #(
    parameter int SAMPLE_CYC  = 50,
    parameter int TIMEOUT_CYC = 250,
    parameter int NUM_BITS    = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic        JB_RX,
    output logic        rx_done,
    output logic [7:0]  jb_cntlr_status,
    output logic [15:0] jb_cntlr_data
);

    localparam int CNT_MAX = (TIMEOUT_CYC > SAMPLE_CYC) ? TIMEOUT_CYC : SAMPLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(NUM_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        SAMPLE,
        WAIT_HIGH,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_q, sync_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic                rx_done_q, rx_done_d;
    logic [7:0]          status_q, status_d;
    logic [15:0]         data_q, data_d;

    logic line;
    logic fall;
    logic rise;
    logic to_hit;

    // [0],[1] form the synchronizer; [2] holds the previous synced value
    assign line   = sync_q[1];
    assign fall   = sync_q[2] & ~sync_q[1];
    assign rise   = ~sync_q[2] & sync_q[1];
    assign to_hit = (cnt_q >= CW'(TIMEOUT_CYC - 1));

    // Next-state, bit sampling, and output capture
    always_comb begin
        sync_d    = {sync_q[1:0], JB_RX};
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_done_d = 1'b0;
        status_d  = status_q;
        data_d    = data_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            WAIT_FALL: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = (bit_cnt_q < BW'(NUM_BITS)) ? SAMPLE : STOP;
                end else if (to_hit) begin
                    state_d = IDLE;
                end
            end
            SAMPLE: begin
                if (cnt_q == CW'(SAMPLE_CYC)) begin
                    shift_d   = {shift_q[NUM_BITS-2:0], line};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (line) begin
                    cnt_d   = '0;
                    state_d = WAIT_FALL;
                end else if (to_hit) begin
                    state_d = IDLE;
                end
            end
            STOP: begin
                if (rise) begin
                    status_d  = shift_q[NUM_BITS-1 -: 8];
                    data_d    = shift_q[15:0];
                    rx_done_d = 1'b1;
                    state_d   = IDLE;
                end else if (to_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Arming always restarts the frame from the first bit
        if (rx_start) begin
            bit_cnt_d = '0;
            cnt_d     = '0;
            state_d   = WAIT_FALL;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 3'b111;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_done_q <= 1'b0;
            status_q  <= 8'h00;
            data_q    <= 16'h0000;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_done_q <= rx_done_d;
            status_q  <= status_d;
            data_q    <= data_d;
        end
    end

    assign rx_done         = rx_done_q;
    assign jb_cntlr_status = status_q;
    assign jb_cntlr_data   = data_q;

endmodule

// File: tb/tb_joybus_rx.sv
// Bench for joybus_rx: bit-accurate line driver with an expected/observed
// frame scoreboard.
module tb_joybus_rx;

    localparam int US = 25;

    logic        clk;
    logic        rst_n;
    logic        rx_start;
    logic        JB_RX;
    logic        rx_done;
    logic [7:0]  jb_cntlr_status;
    logic [15:0] jb_cntlr_data;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    logic [7:0]  last_status;
    logic [15:0] last_data;

    joybus_rx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_start        (rx_start),
        .JB_RX           (JB_RX),
        .rx_done         (rx_done),
        .jb_cntlr_status (jb_cntlr_status),
        .jb_cntlr_data   (jb_cntlr_data)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Record every completed frame just after the edge that produced it
    always @(posedge clk) begin
        #1;
        if (rst_n && rx_done) begin
            obs_q.push_back({jb_cntlr_status, jb_cntlr_data});
            done_cnt++;
        end
    end

    task automatic send_bit(input logic b, input logic arm);
        int lo;
        int hi;
        lo = b ? US : 3 * US;
        hi = 4 * US - lo;
        JB_RX    = 1'b0;
        rx_start = arm;
        @(negedge clk);
        rx_start = 1'b0;
        repeat (lo - 1) @(negedge clk);
        JB_RX = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_stop();
        JB_RX = 1'b0;
        repeat (2 * US) @(negedge clk);
        JB_RX = 1'b1;
        repeat (US) @(negedge clk);
    endtask

    task automatic send_frame(input logic [23:0] w, input logic arm);
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i], arm && (i == 23));
        end
        send_stop();
    endtask

    task automatic wait_obs(input string name, output bit ok);
        int n;
        n = 0;
        while (obs_q.size() == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (obs_q.size() != 0);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: no rx_done within 1000 clocks (got 0 frames, need 1)", name);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_start = 1'b0;
        JB_RX    = 1'b1;
        repeat (3) @(negedge clk);
        checks += 3;
        if (rx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b need 0", rx_done);
        end
        if (jb_cntlr_status !== 8'h00) begin
            failures++;
            $display("FAIL reset_status: got %h need 00", jb_cntlr_status);
        end
        if (jb_cntlr_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data: got %h need 0000", jb_cntlr_data);
        end
        rst_n = 1'b1;
        last_status = 8'h00;
        last_data   = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame(input string name, input logic [23:0] w);
        logic [23:0] want;
        logic [23:0] got;
        bit ok;
        exp_q.push_back(w);
        send_frame(w, 1'b1);
        wait_obs(name, ok);
        want = exp_q.pop_front();
        if (ok) begin
            got = obs_q.pop_front();
            checks += 2;
            if (got[23:16] !== want[23:16]) begin
                failures++;
                $display("FAIL %s_status: got %h need %h", name, got[23:16], want[23:16]);
            end
            if (got[15:0] !== want[15:0]) begin
                failures++;
                $display("FAIL %s_data: got %h need %h", name, got[15:0], want[15:0]);
            end
        end
        last_status = want[23:16];
        last_data   = want[15:0];
    endtask

    task automatic test_basic();
        test_frame("basic", 24'h05_7301);
    endtask

    task automatic test_all_ones();
        int d0;
        d0 = done_cnt;
        test_frame("ones", 24'hFF_FFFF);
        repeat (300) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL ones_pulses: got %0d need 1", done_cnt - d0);
        end
    endtask

    task automatic check_idle(input string name, input int d0);
        checks += 3;
        if (done_cnt !== d0) begin
            failures++;
            $display("FAIL %s_done: got %0d pulses need 0", name, done_cnt - d0);
        end
        if (jb_cntlr_status !== last_status) begin
            failures++;
            $display("FAIL %s_status: got %h need %h", name, jb_cntlr_status, last_status);
        end
        if (jb_cntlr_data !== last_data) begin
            failures++;
            $display("FAIL %s_data: got %h need %h", name, jb_cntlr_data, last_data);
        end
    endtask

    task automatic test_timeout();
        int d0;
        logic [11:0] bits;
        d0 = done_cnt;
        bits = 12'hA5C;
        for (int i = 11; i >= 0; i--) begin
            send_bit(bits[i], i == 11);
        end
        repeat (400) @(negedge clk);
        check_idle("timeout", d0);
    endtask

    task automatic test_no_arm();
        int d0;
        d0 = done_cnt;
        send_frame(24'h12_3456, 1'b0);
        repeat (400) @(negedge clk);
        check_idle("noarm", d0);
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        bits = 10'h2B3;
        for (int i = 9; i >= 0; i--) begin
            send_bit(bits[i], i == 9);
        end
        JB_RX = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (rx_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_done: got %b need 0", rx_done);
        end
        if (jb_cntlr_status !== 8'h00) begin
            failures++;
            $display("FAIL midrst_status: got %h need 00", jb_cntlr_status);
        end
        if (jb_cntlr_data !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_data: got %h need 0000", jb_cntlr_data);
        end
        JB_RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_status = 8'h00;
        last_data   = 16'h0000;
        repeat (5) @(negedge clk);
        test_frame("after_rst", 24'hA5_5AC3);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        test_frame("b2b_first", 24'h05_7301);
        test_frame("b2b_second", 24'h00_8000);
        checks++;
        if (done_cnt - d0 !== 2) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d need 2", done_cnt - d0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_start = 1'b0;
        JB_RX    = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_all_ones();
        test_timeout();
        test_no_arm();
        test_reset_midframe();
        test_back_to_back();
        repeat (50) @(negedge clk);
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL stray_frames: got %0d extra need 0", obs_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
